// File: rtl/microwave_ctrl_p_pkg.sv
// Shared types and constants for the parametrised microwave controller.
package microwave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Segment order {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam int unsigned POWER_MAX   = 10;
  localparam int unsigned WINDOW_SECS = 10;

  // Out-of-range power requests run at full power
  function automatic logic [3:0] clamp_power(input logic [3:0] p);
    return ((p == 4'd0) || (p > 4'(POWER_MAX))) ? 4'(POWER_MAX) : p;
  endfunction

endpackage

// File: rtl/microwave_ctrl_p_if.sv
// Front-panel / magnetron / display signal bundle for microwave_ctrl_p.
interface microwave_ctrl_p_if #(
  parameter int unsigned MIN_DIGITS = 1
);
  logic [9:0]              keys;
  logic                    startn;
  logic                    stopn;
  logic                    clearn;
  logic                    door_closed;
  logic [3:0]              power_level;
  logic                    mag_on;
  logic                    done;
  logic [6:0]              ssec_ones;
  logic [6:0]              ssec_tens;
  logic [7*MIN_DIGITS-1:0] smin;

  modport master (
    output keys, startn, stopn, clearn, door_closed, power_level,
    input  mag_on, done, ssec_ones, ssec_tens, smin
  );

  modport slave (
    input  keys, startn, stopn, clearn, door_closed, power_level,
    output mag_on, done, ssec_ones, ssec_tens, smin
  );
endinterface

// File: rtl/microwave_ctrl_p_bcd_to_7seg.sv
// BCD digit to seven-segment decoder; non-decimal codes are blanked.
module bcd_to_7seg
  import microwave_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_digit)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/microwave_ctrl_p.sv
// Microwave controller: keypad time entry, BCD countdown, duty-cycled magnetron,
// pause/resume and a timed done beep.
module microwave_ctrl_p
  import microwave_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC  = 100,
  parameter int unsigned MIN_DIGITS     = 1,
  parameter int unsigned DONE_BEEP_SECS = 3
) (
  input  logic             clock,
  input  logic             reset,
  microwave_ctrl_p_if.slave bus
);

  localparam int unsigned TW          = $clog2(TICKS_PER_SEC);
  localparam int unsigned DW          = 4 * (2 + MIN_DIGITS);
  localparam int unsigned BEEP_CYCLES = DONE_BEEP_SECS * TICKS_PER_SEC;
  localparam int unsigned BW          = $clog2(BEEP_CYCLES + 1);

  state_t          r_state, w_state_nx;
  logic [DW-1:0]   r_digits, w_digits_nx, w_digits_dec;
  logic [TW-1:0]   r_tick, w_tick_nx;
  logic [3:0]      r_window, w_window_nx;
  logic [3:0]      r_power, w_power_nx;
  logic [BW-1:0]   r_beep, w_beep_nx;
  logic            r_mag, r_done;
  logic            w_mag_nx, w_done_nx;
  logic            r_start_prev, r_stop_prev, r_clear_prev, r_key_prev;
  logic            w_start_ev, w_stop_ev, w_clear_ev, w_key_ev;
  logic            w_door_open, w_tick_fire;
  logic [3:0]      w_key_digit;

  // Seconds-first BCD decrement with borrow rippling through the minute digits
  function automatic logic [DW-1:0] bcd_dec(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    logic          borrow;
    r      = d;
    borrow = 1'b0;
    if (d[3:0] != 4'd0) begin
      r[3:0] = d[3:0] - 4'd1;
    end else if (d[7:4] != 4'd0) begin
      r[7:4] = d[7:4] - 4'd1;
      r[3:0] = 4'd9;
    end else begin
      r[7:4] = 4'd5;
      r[3:0] = 4'd9;
      borrow = 1'b1;
      for (int unsigned i = 2; i < 2 + MIN_DIGITS; i++) begin
        if (borrow) begin
          if (r[4*i +: 4] != 4'd0) begin
            r[4*i +: 4] = r[4*i +: 4] - 4'd1;
            borrow      = 1'b0;
          end else begin
            r[4*i +: 4] = 4'd9;
          end
        end
      end
    end
    return r;
  endfunction

  // Buttons are tracked as "was active"; reset to 1 so a held button never fires
  assign w_start_ev  = ~bus.startn & ~r_start_prev;
  assign w_stop_ev   = ~bus.stopn  & ~r_stop_prev;
  assign w_clear_ev  = ~bus.clearn & ~r_clear_prev;
  assign w_key_ev    = (bus.keys != '0) && ((bus.keys & (bus.keys - 10'd1)) == '0) && !r_key_prev;
  assign w_door_open = ~bus.door_closed;
  assign w_tick_fire = (r_tick == TW'(TICKS_PER_SEC - 1));
  assign w_digits_dec = bcd_dec(r_digits);

  always_comb begin
    w_key_digit = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (bus.keys[i]) w_key_digit = 4'(i);
    end
  end

  // Next state: each state acts on its highest-priority event that has a meaning there
  always_comb begin
    w_state_nx  = r_state;
    w_digits_nx = r_digits;
    w_tick_nx   = r_tick;
    w_window_nx = r_window;
    w_power_nx  = r_power;
    w_beep_nx   = r_beep;
    case (r_state)
      ST_IDLE, ST_SET: begin
        if (w_clear_ev) begin
          w_state_nx  = ST_IDLE;
          w_digits_nx = '0;
        end else if (w_start_ev && bus.door_closed && (r_state == ST_SET)) begin
          w_state_nx  = ST_COOK;
          w_power_nx  = clamp_power(bus.power_level);
          w_tick_nx   = '0;
          w_window_nx = 4'd0;
        end else if (w_key_ev) begin
          w_digits_nx = {r_digits[DW-5:0], w_key_digit};
          w_state_nx  = (w_digits_nx != '0) ? ST_SET : ST_IDLE;
        end
      end
      ST_COOK: begin
        if (w_clear_ev) begin
          w_state_nx  = ST_IDLE;
          w_digits_nx = '0;
        end else if (w_door_open || w_stop_ev) begin
          w_state_nx = ST_PAUSE;
        end else if (w_tick_fire) begin
          w_tick_nx   = '0;
          w_digits_nx = w_digits_dec;
          w_window_nx = (r_window == 4'(WINDOW_SECS - 1)) ? 4'd0 : r_window + 4'd1;
          if (w_digits_dec == '0) begin
            w_state_nx = ST_DONE;
            w_beep_nx  = '0;
          end
        end else begin
          w_tick_nx = r_tick + TW'(1);
        end
      end
      ST_PAUSE: begin
        if (w_clear_ev || w_stop_ev) begin
          w_state_nx  = ST_IDLE;
          w_digits_nx = '0;
        end else if (w_start_ev && bus.door_closed) begin
          w_state_nx = ST_COOK;
        end
      end
      ST_DONE: begin
        if (w_start_ev || w_stop_ev || w_clear_ev || w_door_open) begin
          w_state_nx  = ST_IDLE;
          w_digits_nx = '0;
        end else if (r_beep == BW'(BEEP_CYCLES - 1)) begin
          w_state_nx = ST_IDLE;
        end else begin
          w_beep_nx = r_beep + BW'(1);
        end
      end
      default: begin
        w_state_nx  = ST_IDLE;
        w_digits_nx = '0;
      end
    endcase
  end

  assign w_mag_nx  = (w_state_nx == ST_COOK) && (w_window_nx < w_power_nx);
  assign w_done_nx = (w_state_nx == ST_DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_digits     <= '0;
      r_tick       <= '0;
      r_window     <= 4'd0;
      r_power      <= 4'd0;
      r_beep       <= '0;
      r_mag        <= 1'b0;
      r_done       <= 1'b0;
      r_start_prev <= 1'b1;
      r_stop_prev  <= 1'b1;
      r_clear_prev <= 1'b1;
      r_key_prev   <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_digits     <= w_digits_nx;
      r_tick       <= w_tick_nx;
      r_window     <= w_window_nx;
      r_power      <= w_power_nx;
      r_beep       <= w_beep_nx;
      r_mag        <= w_mag_nx;
      r_done       <= w_done_nx;
      r_start_prev <= ~bus.startn;
      r_stop_prev  <= ~bus.stopn;
      r_clear_prev <= ~bus.clearn;
      r_key_prev   <= |bus.keys;
    end
  end

  // Door switch gates the magnetron with no register in the path
  assign bus.mag_on = r_mag & bus.door_closed;
  assign bus.done   = r_done;

  bcd_to_7seg u_seg_ones (.i_digit(r_digits[3:0]), .o_seg(bus.ssec_ones));
  bcd_to_7seg u_seg_tens (.i_digit(r_digits[7:4]), .o_seg(bus.ssec_tens));

  for (genvar g = 0; g < MIN_DIGITS; g++) begin : g_min
    bcd_to_7seg u_seg_min (.i_digit(r_digits[4*(g+2) +: 4]), .o_seg(bus.smin[7*g +: 7]));
  end

endmodule

// File: tb/tb_microwave_ctrl_p.sv
// Bench for microwave_ctrl_p: seconds-level behavioural model checked every cycle,
// directed scenarios with literal expectations, then randomized panel activity.
module tb_microwave_ctrl_p;

  localparam int TPS       = 4;
  localparam int MIN_D     = 1;
  localparam int BEEP_S    = 3;
  localparam int BEEP_CYC  = BEEP_S * TPS;
  localparam int DISP_MOD  = (MIN_D == 2) ? 10000 : 1000;
  localparam int MIN_MOD   = (MIN_D == 2) ? 100 : 10;
  localparam int MD_IDLE   = 0;
  localparam int MD_SET    = 1;
  localparam int MD_COOK   = 2;
  localparam int MD_PAUSE  = 3;
  localparam int MD_DONE   = 4;
  localparam logic [6:0] S0 = 7'b0111111;
  localparam logic [20:0] DISP_ZERO = {S0, S0, S0};

  logic clock = 1'b0;
  logic reset = 1'b1;

  microwave_ctrl_p_if #(.MIN_DIGITS(MIN_D)) bus ();

  microwave_ctrl_p #(
    .TICKS_PER_SEC (TPS),
    .MIN_DIGITS    (MIN_D),
    .DONE_BEEP_SECS(BEEP_S)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Model: display held as a decimal number (m:ss -> m*100+ss), cook progress in cycles/seconds
  int m_mode, m_disp, m_sub, m_elapsed, m_power, m_beep_left;
  bit m_start_prev, m_stop_prev, m_clear_prev, m_keys_prev_zero;

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [7*MIN_D+13:0] exp_disp(input int v);
    logic [7*MIN_D+13:0] r;
    int mm;
    r[6:0]  = seg(v % 10);
    r[13:7] = seg((v / 10) % 10);
    mm = v / 100;
    for (int g = 0; g < MIN_D; g++) begin
      r[14+7*g +: 7] = seg(mm % 10);
      mm = mm / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock or posedge reset) begin : model
    int md, dp, sb, el, pw, bl, kd, ss, mm, pl;
    bit st_ev, sp_ev, cl_ev, key_ev, door;
    if (reset) begin
      m_mode <= MD_IDLE; m_disp <= 0; m_sub <= 0; m_elapsed <= 0;
      m_power <= 0; m_beep_left <= 0;
      m_start_prev <= 1'b1; m_stop_prev <= 1'b1; m_clear_prev <= 1'b1;
      m_keys_prev_zero <= 1'b1;
    end else begin
      md = m_mode; dp = m_disp; sb = m_sub; el = m_elapsed; pw = m_power; bl = m_beep_left;
      door   = bus.door_closed;
      pl     = int'(bus.power_level);
      st_ev  = !bus.startn && !m_start_prev;
      sp_ev  = !bus.stopn  && !m_stop_prev;
      cl_ev  = !bus.clearn && !m_clear_prev;
      key_ev = ($countones(bus.keys) == 1) && m_keys_prev_zero;
      kd = 0;
      for (int i = 0; i < 10; i++) if (bus.keys[i]) kd = i;
      case (md)
        MD_IDLE, MD_SET: begin
          if (cl_ev) begin
            md = MD_IDLE; dp = 0;
          end else if (st_ev && door && md == MD_SET) begin
            md = MD_COOK; pw = (pl == 0 || pl > 10) ? 10 : pl; sb = 0; el = 0;
          end else if (key_ev) begin
            dp = (dp * 10 + kd) % DISP_MOD;
            md = (dp != 0) ? MD_SET : MD_IDLE;
          end
        end
        MD_COOK: begin
          if (cl_ev) begin
            md = MD_IDLE; dp = 0;
          end else if (!door || sp_ev) begin
            md = MD_PAUSE;
          end else begin
            sb++;
            if (sb == TPS) begin
              sb = 0; el++;
              ss = dp % 100; mm = dp / 100;
              if (ss > 0) ss--;
              else begin mm = (mm + MIN_MOD - 1) % MIN_MOD; ss = 59; end
              dp = mm * 100 + ss;
              if (dp == 0) begin md = MD_DONE; bl = BEEP_CYC; end
            end
          end
        end
        MD_PAUSE: begin
          if (cl_ev || sp_ev) begin
            md = MD_IDLE; dp = 0;
          end else if (st_ev && door) begin
            md = MD_COOK;
          end
        end
        MD_DONE: begin
          if (st_ev || sp_ev || cl_ev || !door) begin
            md = MD_IDLE; dp = 0;
          end else begin
            bl--;
            if (bl == 0) md = MD_IDLE;
          end
        end
        default: md = MD_IDLE;
      endcase
      m_mode <= md; m_disp <= dp; m_sub <= sb; m_elapsed <= el; m_power <= pw; m_beep_left <= bl;
      m_start_prev <= !bus.startn; m_stop_prev <= !bus.stopn; m_clear_prev <= !bus.clearn;
      m_keys_prev_zero <= (bus.keys == '0);
    end
  end

  always @(posedge clock) begin
    #2;
    if (cmp_en) begin
      check("mag_on", 32'(bus.mag_on),
            32'((m_mode == MD_COOK) && ((m_elapsed % 10) < m_power) && bus.door_closed));
      check("done", 32'(bus.done), 32'(m_mode == MD_DONE));
      check("display", 32'({bus.smin, bus.ssec_tens, bus.ssec_ones}), 32'(exp_disp(m_disp)));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic key(input int k);
    @(negedge clock); bus.keys = 10'(1 << k);
    @(negedge clock); bus.keys = '0;
  endtask

  task automatic press_start;
    @(negedge clock); bus.startn = 1'b0;
    @(negedge clock); bus.startn = 1'b1;
  endtask

  task automatic press_stop;
    @(negedge clock); bus.stopn = 1'b0;
    @(negedge clock); bus.stopn = 1'b1;
  endtask

  task automatic press_clear;
    @(negedge clock); bus.clearn = 1'b0;
    @(negedge clock); bus.clearn = 1'b1;
  endtask

  function automatic logic [31:0] disp_now();
    return 32'({bus.smin, bus.ssec_tens, bus.ssec_ones});
  endfunction

  initial begin
    int cnt, dcnt;
    bit found, m0, m12, m40;
    bus.keys = '0; bus.startn = 1'b1; bus.stopn = 1'b1; bus.clearn = 1'b1;
    bus.door_closed = 1'b1; bus.power_level = 4'd10;
    tick(3);
    reset = 1'b0;
    cmp_en = 1'b1;
    tick(1);
    check("rst_mag", 32'(bus.mag_on), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_disp", disp_now(), 32'(DISP_ZERO));

    // 1:05 at full power: 65 s of magnetron, then a 3 s beep
    key(1); key(0); key(5);
    check("disp_105", disp_now(), 32'({7'b0000110, 7'b0111111, 7'b1101101}));
    press_start;
    cnt = 0; dcnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (bus.mag_on) cnt++;
      if (bus.done) dcnt++;
      @(negedge clock);
    end
    check("mag_cycles_105", 32'(cnt), 32'd260);
    check("done_cycles", 32'(dcnt), 32'd12);
    check("idle_after_done", disp_now(), 32'(DISP_ZERO));

    // Door opens at 0:40, closing alone does not resume, start finishes remaining 40 s
    key(1); key(0); key(0);
    press_start;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clock);
      if (m_disp == 40) found = 1'b1;
    end
    check("reach_040", 32'(found), 32'd1);
    bus.door_closed = 1'b0;
    #1;
    check("door_cutoff", 32'(bus.mag_on), 32'd0);
    tick(3);
    check("pause_040", disp_now(), 32'({S0, 7'b1100110, S0}));
    bus.door_closed = 1'b1;
    tick(3);
    check("still_paused_mag", 32'(bus.mag_on), 32'd0);
    check("still_paused_disp", disp_now(), 32'({S0, 7'b1100110, S0}));
    press_start;
    cnt = 0;
    while (!bus.done && cnt < 400) begin
      @(negedge clock); cnt++;
    end
    check("resume_to_done", 32'(cnt), 32'd160);
    tick(BEEP_CYC + 2);

    // Power 3 duty cycle over a 20 s cook
    bus.power_level = 4'd3;
    key(2); key(0);
    press_start;
    cnt = 0; m0 = 0; m12 = 0; m40 = 0;
    for (int i = 0; i < 80; i++) begin
      if (bus.mag_on) cnt++;
      if (i == 0)  m0  = bus.mag_on;
      if (i == 12) m12 = bus.mag_on;
      if (i == 40) m40 = bus.mag_on;
      @(negedge clock);
    end
    check("pwr3_cycles", 32'(cnt), 32'd24);
    check("pwr3_sec0", 32'(m0), 32'd1);
    check("pwr3_sec3", 32'(m12), 32'd0);
    check("pwr3_sec10", 32'(m40), 32'd1);
    tick(BEEP_CYC + 2);

    // Power 0 behaves as full power
    bus.power_level = 4'd0;
    key(5);
    press_start;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.mag_on) cnt++;
      @(negedge clock);
    end
    check("pwr0_cycles", 32'(cnt), 32'd20);
    tick(BEEP_CYC + 2);
    bus.power_level = 4'd10;

    // Key entry rules
    key(1); key(2); key(3); key(4);
    check("disp_234", disp_now(), 32'({7'b1011011, 7'b1001111, 7'b1100110}));
    press_clear;
    check("clear_disp", disp_now(), 32'(DISP_ZERO));
    key(0);
    press_start;
    tick(1);
    check("zero_key_no_cook", 32'(bus.mag_on), 32'd0);
    @(negedge clock); bus.keys = 10'b0000000011;
    @(negedge clock); bus.keys = '0;
    check("multihot_ignored", disp_now(), 32'(DISP_ZERO));
    key(5);
    press_start;
    key(7);
    check("cook_key_ignored", disp_now(), 32'({S0, S0, 7'b1101101}));
    check("cook_mag", 32'(bus.mag_on), 32'd1);
    press_clear;

    // Clear beats start in SET; stop in PAUSE returns to IDLE
    key(8);
    @(negedge clock); bus.clearn = 1'b0; bus.startn = 1'b0;
    @(negedge clock); bus.clearn = 1'b1; bus.startn = 1'b1;
    check("clr_start_mag", 32'(bus.mag_on), 32'd0);
    check("clr_start_disp", disp_now(), 32'(DISP_ZERO));
    key(9);
    press_start;
    press_stop;
    check("pause_009", disp_now(), 32'({S0, S0, 7'b1101111}));
    check("pause_mag", 32'(bus.mag_on), 32'd0);
    press_stop;
    check("stop_pause_idle", disp_now(), 32'(DISP_ZERO));

    // Asynchronous reset mid-cook, start held through reset release
    key(3); key(0);
    press_start;
    tick(5);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("arst_mag", 32'(bus.mag_on), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_disp", disp_now(), 32'(DISP_ZERO));
    bus.startn = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(2);
    key(4);
    tick(3);
    check("held_start_no_cook", 32'(bus.mag_on), 32'd0);
    bus.startn = 1'b1;
    press_start;
    check("start_after_release", 32'(bus.mag_on), 32'd1);
    press_clear;

    // Randomized panel activity against the model
    for (int i = 0; i < 4000; i++) begin
      int r;
      @(negedge clock);
      r = $urandom_range(0, 99);
      if (r < 6)      bus.keys = 10'(1 << $urandom_range(0, 9));
      else if (r < 8) bus.keys = 10'($urandom);
      else            bus.keys = '0;
      bus.startn = ($urandom_range(0, 99) < 5) ? 1'b0 : 1'b1;
      bus.stopn  = ($urandom_range(0, 199) < 1) ? 1'b0 : 1'b1;
      bus.clearn = ($urandom_range(0, 299) < 1) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 149) == 0) bus.door_closed = ~bus.door_closed;
      if ($urandom_range(0, 19) == 0)  bus.power_level = 4'($urandom_range(0, 15));
    end
    @(negedge clock);
    bus.keys = '0; bus.startn = 1'b1; bus.stopn = 1'b1; bus.clearn = 1'b1;
    bus.door_closed = 1'b1;
    tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/microwave_ctrl_p.md
# microwave_ctrl_p

Parametrised successor to the fixed-format `microwave` controller. It provides:
- configurable tick rate and number of minute digits;
- a duty-cycled power level;
- pause/resume on door-open or stop;
- a timed "done" beep.

It sits between the debounced front-panel inputs (keypad, start/stop/clear buttons, door switch) and the magnetron driver plus seven-segment display.

## Interface
Parameters:
- TICKS_PER_SEC, 100, clock cycles per second of cook time (≥2)
- MIN_DIGITS, 1, number of BCD minute digits (1..2)
- DONE_BEEP_SECS, 3, seconds `done` stays asserted after countdown completes

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- keys  in  10  keypad, one-hot, bit n = digit n
- startn  in  1  start button, active-low
- stopn  in  1  stop button, active-low
- clearn  in  1  clear button, active-low
- door_closed  in  1  1 = door closed
- power_level  in  4  power 1..10, sampled at start
- mag_on  out  1  magnetron enable
- done  out  1  end-of-cook beep
- ssec_ones  out  7  seconds-ones segments {g,f,e,d,c,b,a}, active-high
- ssec_tens  out  7  seconds-tens segments
- smin  out  7*MIN_DIGITS  minute digits, least significant digit in [6:0]

## Operation
- States: IDLE, SET, COOK, PAUSE, DONE.
- Reset (async) forces:
  - state = IDLE, all digits 0, mag_on = 0, done = 0;
  - tick and window counters 0;
  - button-previous flops 1, key-previous flop 0.
- Press event: the input is sampled active at this edge and was inactive at the previous edge. A button held through reset never fires.
- Key event: keys nonzero and exactly one bit set this edge, keys == 0 at the previous edge. Multi-hot patterns are ignored.
- Key event in IDLE/SET:
  - all digits shift one place left and the new digit enters seconds-ones;
  - the top minute digit is discarded on overflow;
  - resulting time nonzero → SET; zero → IDLE.
- Keys are ignored in COOK, PAUSE and DONE.
- Event priority, highest first: clear > door open > stop > start > key.
- SET:
  - clear → IDLE with digits zeroed;
  - start with door_closed → COOK: latch power (0 or >10 becomes 10), zero the tick and window counters;
  - start with door open → ignored.
- COOK:
  - a one-second tick fires every TICKS_PER_SEC cycles and decrements the BCD time by one second;
  - door open or stop → PAUSE, counters hold;
  - clear → IDLE;
  - the decrement reaching 0:00 → DONE.
- PAUSE:
  - start with door_closed → COOK, counters resume from held values, power is not re-sampled;
  - clear or stop → IDLE;
  - closing the door alone does not resume.
- DONE:
  - done = 1 for DONE_BEEP_SECS seconds, then IDLE;
  - any button press or door open → IDLE immediately.
- BCD decrement rules:
  - ones > 0 → ones - 1;
  - ones = 0, tens > 0 → tens - 1, ones = 9;
  - both 0 → borrow 1 from the minutes (multi-digit BCD), tens = 5, ones = 9.
- Tens digits above 5 are legal on entry and count down normally (1:90 → 1:89).
- Power duty cycle:
  - a window counter runs 0..9 seconds and advances on each tick in COOK only;
  - the mag_on register = state is COOK and window < power.
- mag_on output = mag_on register AND door_closed. The door gating is combinational: a safety cutoff with zero latency.
- Displays decode the registered digits combinationally. Encodings: 0 = 0111111, 1 = 0000110, 5 = 1101101.

## Timing
- A press or key event changes state and digits on the same edge that samples it.
- Entering COOK sets the mag_on register on that edge. The first decrement comes TICKS_PER_SEC cycles later.
- Total cook time for T seconds = T·TICKS_PER_SEC cycles from the start edge to DONE entry.
- mag_on falls on the edge entering PAUSE, DONE or IDLE. It falls immediately (combinationally) when door_closed goes low.
- done rises on the DONE-entry edge and falls after exactly DONE_BEEP_SECS·TICKS_PER_SEC cycles.
- Tick counter width: $clog2(TICKS_PER_SEC). It wraps to 0 when it fires.

## Structure
- `microwave_pkg` holds:
  - state enum;
  - seven-segment constants for 0..9 and blank;
  - POWER_MAX = 10, WINDOW_SECS = 10.
- Sub-module `bcd_to_7seg`: 4-bit digit in, 7-bit segments out. Instantiated 2+MIN_DIGITS times.
- Top level holds the FSM, digit shift register, decrementer, tick/window/beep counters and edge detectors.

## Test plan
- Keys 1,0,5 → display 1:05; start, power 10, TICKS_PER_SEC = 4 → mag_on high 260 cycles, then done high 12 cycles, then IDLE at 0:00.
- Door opens at 0:40 while cooking → mag_on low in the same cycle, PAUSE holds 0:40. Close the door → still paused. Start → resumes, reaches DONE after the remaining 40 s.
- Power 3, 0:20 cook → mag_on high for seconds 0-2 and 10-12, low otherwise. Power 0 → always high.
- MIN_DIGITS = 1, keys 1,2,3,4 → 2:34. Key 0 from IDLE stays IDLE. Keys 0000000011 ignored. Key pressed during COOK ignored.
- In SET, clearn and startn fall together → IDLE, mag_on 0. In PAUSE, stop → IDLE.
- Reset asserted mid-cook between edges → mag_on, done and all digits 0 immediately. Startn held low through reset release → no start.
